// File: rtl/pv_run_controller.sv
// Run-control and trace unit for philosophy_v_core: streams a program into IMEM,
// gates the core clock-enable (free-run / step / run-until-EBREAK) and queues trace records.
//
// state | meaning
// IDLE  | core held in reset, accepting program beats or a start for a preloaded program
// LOAD  | streaming program words into IMEM
// READY | core out of reset, waiting for start
// RUN   | core enabled every cycle the trace FIFO has room
// STEP  | core enabled only on a step pulse
// DRAIN | run terminated, waiting for the trace FIFO to empty
// DONE  | run finished, cause held until start
module pv_run_controller #(
    parameter int XLEN        = 32,
    parameter int ILEN        = 32,
    parameter int IMEM_DEPTH  = 1024,
    parameter int ADDR_W      = 10,
    parameter int CYC_W       = 32,
    parameter int TRACE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cfg_mode,
    input  logic [CYC_W-1:0]  cfg_max_cycles,
    input  logic              start,
    input  logic              step,
    input  logic              halt_req,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ILEN-1:0]   load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [ILEN-1:0]   imem_wdata,
    output logic              core_rst_n,
    output logic              core_en,
    input  logic [XLEN-1:0]   core_pc,
    input  logic [ILEN-1:0]   core_instr,
    input  logic [XLEN-1:0]   core_result,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [XLEN-1:0]   trace_pc,
    output logic [ILEN-1:0]   trace_instr,
    output logic [XLEN-1:0]   trace_result,
    output logic [CYC_W-1:0]  trace_cycle,
    output logic [2:0]        state,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              done,
    output logic [1:0]        done_cause
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READY = 3'd2,
        RUN   = 3'd3,
        STEP  = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int REC_W = XLEN + ILEN + XLEN + CYC_W;
    localparam logic [ILEN-1:0]   EBREAK   = ILEN'(32'h0010_0073);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(IMEM_DEPTH - 1);

    state_t            st, st_n;
    logic [ADDR_W-1:0] load_ptr;
    logic              beat, last_beat;
    logic [CYC_W-1:0]  cyc_inc;
    logic              in_run, is_ebreak, budget_hit;

    logic [REC_W-1:0]  fifo_mem [TRACE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_full, fifo_push, fifo_pop;

    assign state       = st;
    assign beat        = load_valid && load_ready;
    assign last_beat   = beat && (load_last || load_ptr == LAST_ADR);
    assign in_run      = (st == RUN) || (st == STEP);
    assign fifo_full   = (fifo_cnt == (PTR_W+1)'(TRACE_DEPTH));
    assign core_en     = ((st == RUN) || (st == STEP && step)) && !fifo_full && !halt_req;
    assign cyc_inc     = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
    assign is_ebreak   = core_en && (cfg_mode == 2'b10) && (core_instr == EBREAK);
    assign budget_hit  = core_en && (cfg_max_cycles != '0) && (cyc_inc == cfg_max_cycles);
    assign fifo_push   = core_en;
    assign trace_valid = (fifo_cnt != '0);
    assign fifo_pop    = trace_valid && trace_ready;
    assign {trace_pc, trace_instr, trace_result, trace_cycle} = fifo_mem[rd_ptr];

    always_comb begin
        st_n = st;
        case (st)
            IDLE:    if (beat) st_n = last_beat ? READY : LOAD;
                     else if (start) st_n = READY;
            LOAD:    if (last_beat) st_n = READY;
            READY:   if (start) st_n = (cfg_mode == 2'b01) ? STEP : RUN;
            RUN,
            STEP:    if (halt_req || is_ebreak || budget_hit) st_n = DRAIN;
            DRAIN:   if (fifo_cnt == '0) st_n = DONE;
            DONE:    if (start) st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            load_ready  <= 1'b0;
            core_rst_n  <= 1'b0;
            done        <= 1'b0;
            done_cause  <= 2'b00;
            cycle_count <= '0;
            load_ptr    <= '0;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            imem_wdata  <= '0;
        end else begin
            st         <= st_n;
            load_ready <= (st_n == IDLE) || (st_n == LOAD);
            core_rst_n <= !((st_n == IDLE) || (st_n == LOAD));
            done       <= (st_n == DONE);
            imem_we    <= beat;
            if (beat) begin
                imem_waddr <= load_ptr;
                imem_wdata <= load_data;
                if (load_ptr != LAST_ADR) load_ptr <= load_ptr + 1'b1;
            end
            if (st == READY && start) cycle_count <= '0;
            if (core_en) cycle_count <= cyc_inc;
            // halt wins over EBREAK, which wins over the budget
            if (in_run) begin
                if (halt_req)        done_cause <= 2'b11;
                else if (is_ebreak)  done_cause <= 2'b10;
                else if (budget_hit) done_cause <= 2'b01;
            end
            if (st_n == IDLE && st != IDLE) begin
                cycle_count <= '0;
                done_cause  <= 2'b00;
                load_ptr    <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= {core_pc, core_instr, core_result, cyc_inc};
    end
endmodule

// File: tb/tb_pv_run_controller.sv
// Bench for pv_run_controller: acts as the core, scoreboards every trace record,
// and runs a table of run configurations plus load / step / backpressure / reset sequences.
module tb_pv_run_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_max_cycles;
    logic        start, step, halt_req;
    logic        load_valid, load_ready, load_last;
    logic [31:0] load_data;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst_n, core_en;
    logic [31:0] core_pc, core_instr, core_result;
    logic        trace_valid, trace_ready;
    logic [31:0] trace_pc, trace_instr, trace_result, trace_cycle;
    logic [2:0]  state;
    logic [31:0] cycle_count;
    logic        done;
    logic [1:0]  done_cause;

    int checks = 0;
    int errors = 0;
    int en_cycles = 0;
    int idx = 0;
    int ebreak_at = -1;
    logic [127:0] sb[$];

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] max;
        int          ebreak_at;
        bit          rnd;
        int          exp_n;
        logic [1:0]  exp_cause;
    } vec_t;
    vec_t vecs[7];

    pv_run_controller dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_max_cycles(cfg_max_cycles),
        .start(start), .step(step), .halt_req(halt_req),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .core_en(core_en),
        .core_pc(core_pc), .core_instr(core_instr), .core_result(core_result),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_result(trace_result), .trace_cycle(trace_cycle),
        .state(state), .cycle_count(cycle_count), .done(done), .done_cause(done_cause)
    );

    always #5 clk = ~clk;

    // core model: one instruction per enabled cycle
    always @(posedge clk) begin
        if (!core_rst_n) idx <= 0;
        else if (core_en) idx <= idx + 1;
    end
    assign core_pc     = 32'(idx) * 32'd4;
    assign core_instr  = (idx == ebreak_at) ? 32'h0010_0073 : (32'h13 | (32'(idx) << 7));
    assign core_result = (32'(idx) * 32'h9e37_79b1) ^ 32'h5a5a;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [127:0] exp;
        forever begin
            @(negedge clk);
            if (!rst_n || !core_rst_n) begin
                sb.delete();
                en_cycles = 0;
            end else begin
                if (trace_valid && trace_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL trace_unexpected: got record cycle %0d expected none", trace_cycle);
                    end else begin
                        exp = sb.pop_front();
                        check("trace_record", {trace_pc, trace_instr, trace_result, trace_cycle}, exp);
                    end
                end
                if (core_en) begin
                    en_cycles++;
                    sb.push_back({core_pc, core_instr, core_result, 32'(en_cycles)});
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_start();
        pulse_start();
        pulse_start();
    endtask

    task automatic wait_done(input int limit, input bit rnd);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                tick();
                if (rnd) trace_ready = 1'($urandom_range(0, 1));
            end
        end
        trace_ready = 1'b1;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", limit);
        end
    endtask

    task automatic end_checks(input int exp_n, input logic [1:0] exp_cause);
        check("done", 128'(done), 128'(1));
        check("state_done", 128'(state), 128'(6));
        check("done_cause", 128'(done_cause), 128'(exp_cause));
        check("cycle_count", 128'(cycle_count), 128'(exp_n));
        check("records", 128'(en_cycles), 128'(exp_n));
        check("sb_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        logic [31:0] words[3];
        int tv_cnt, we_cnt;
        words[0] = 32'hA0A0_0001;
        words[1] = 32'hB0B0_0002;
        words[2] = 32'hC0C0_0003;
        vecs[0] = '{2'b00, 32'd10, -1, 1'b0, 10, 2'b01};
        vecs[1] = '{2'b10, 32'd0,   4, 1'b1,  5, 2'b10};
        vecs[2] = '{2'b11, 32'd7,   2, 1'b0,  7, 2'b01};
        vecs[3] = '{2'b10, 32'd3,   4, 1'b0,  3, 2'b01};
        vecs[4] = '{2'b10, 32'd5,   4, 1'b1,  5, 2'b10};
        vecs[5] = '{2'b00, 32'd1,   0, 1'b1,  1, 2'b01};
        vecs[6] = '{2'b00, 32'd20,  4, 1'b1, 20, 2'b01};

        rst_n = 1'b0; cfg_mode = 2'b00; cfg_max_cycles = '0;
        start = 1'b0; step = 1'b0; halt_req = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0; trace_ready = 1'b1;
        fork monitor(); join_none

        #2;
        check("rst_state", 128'(state), 128'(0));
        check("rst_load_ready", 128'(load_ready), 128'(0));
        check("rst_imem_we", 128'(imem_we), 128'(0));
        check("rst_core_en", 128'(core_en), 128'(0));
        check("rst_core_rst_n", 128'(core_rst_n), 128'(0));
        check("rst_trace_valid", 128'(trace_valid), 128'(0));
        check("rst_done", 128'({done, done_cause}), 128'(0));
        check("rst_cycle_count", 128'(cycle_count), 128'(0));
        tick(); tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("idle_load_ready", 128'(load_ready), 128'(1));
        check("idle_core_rst_n", 128'(core_rst_n), 128'(0));

        // program load: A, B, C with last on C
        for (int k = 0; k < 3; k++) begin
            #1;
            load_valid = 1'b1;
            load_data  = words[k];
            load_last  = (k == 2);
            tick();
            load_valid = 1'b0;
            load_last  = 1'b0;
            @(negedge clk);
            check("imem_write", {imem_we, imem_waddr, imem_wdata}, {1'b1, 10'(k), words[k]});
        end
        check("load_state", 128'(state), 128'(2));
        check("load_ready_off", 128'(load_ready), 128'(0));
        check("ready_core_rst_n", 128'(core_rst_n), 128'(1));
        @(negedge clk);
        check("imem_we_off", 128'(imem_we), 128'(0));
        tick();

        // single-step from READY, then halt with a coincident step
        cfg_mode = 2'b01; cfg_max_cycles = '0;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            repeat (4) tick();
            @(negedge clk);
            check("step_idle_en", 128'(core_en), 128'(0));
            tick();
            step = 1'b1;
            @(negedge clk);
            check("step_en", 128'(core_en), 128'(1));
            tick();
            step = 1'b0;
        end
        tick();
        step = 1'b1; halt_req = 1'b1;
        @(negedge clk);
        check("halt_blocks_en", 128'(core_en), 128'(0));
        tick();
        step = 1'b0; halt_req = 1'b0;
        wait_done(100, 1'b0);
        end_checks(3, 2'b11);
        pulse_start();
        @(negedge clk);
        check("back_to_idle", 128'({state, done, done_cause}), 128'(0));
        tick();

        for (int i = 0; i < 7; i++) begin
            ebreak_at = vecs[i].ebreak_at;
            cfg_mode = vecs[i].mode;
            cfg_max_cycles = vecs[i].max;
            run_start();
            wait_done(400, vecs[i].rnd);
            end_checks(vecs[i].exp_n, vecs[i].exp_cause);
            pulse_start();
        end
        ebreak_at = -1;

        // backpressure: FIFO of 4 fills, two ready cycles free exactly two more instructions
        trace_ready = 1'b0;
        cfg_mode = 2'b00; cfg_max_cycles = 32'd12;
        run_start();
        repeat (10) tick();
        @(negedge clk);
        check("bp_full_count", 128'(en_cycles), 128'(4));
        check("bp_full_en", 128'({core_en, trace_valid}), 128'(2'b01));
        tick();
        trace_ready = 1'b1;
        tick(); tick();
        trace_ready = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("bp_after_pops", 128'(en_cycles), 128'(6));
        check("bp_stalled_en", 128'(core_en), 128'(0));
        tick();
        trace_ready = 1'b1;
        wait_done(200, 1'b0);
        end_checks(12, 2'b01);
        pulse_start();

        // asynchronous reset in the middle of a run
        trace_ready = 1'b0;
        cfg_max_cycles = 32'd10;
        run_start();
        tick(); tick();
        @(negedge clk);
        check("pre_rst_valid", 128'(trace_valid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_state", 128'(state), 128'(0));
        check("midrst_outs", 128'({core_en, core_rst_n, trace_valid, done, load_ready, imem_we}), 128'(0));
        check("midrst_counts", 128'({cycle_count, done_cause}), 128'(0));
        tick(); tick();
        rst_n = 1'b1;
        trace_ready = 1'b1;
        tv_cnt = 0; we_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (trace_valid) tv_cnt++;
            if (imem_we) we_cnt++;
        end
        check("post_rst_no_trace", 128'(tv_cnt), 128'(0));
        check("post_rst_no_write", 128'(we_cnt), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
